alu_exec_unit: RTL
==================

// Module: alu_exec_unit
// PURPOSE
//  Execute-stage ALU that consumes the 4-bit alu_ctrl code produced by ALU control decode.
//  It computes the result for operands op_a/op_b and reports zero (for BEQ) and illegal-code flags.
//  Single-cycle ops return the result one cycle after accept.
//  Shifts are iterative, one bit per cycle, and take 1+shamt cycles.
//  Valid/ready handshakes are used on both sides so the unit can stall the pipeline.
// PARAMETERS
//  XLEN     32   operand/result width
//  SHAMT_W  5    shift-amount width; must equal clog2(XLEN); shamt = op_b[SHAMT_W-1:0]
// PORTS
//  clk       in   1     clock; all state updates on rising edge
//  rst       in   1     synchronous, active-high reset
//  in_valid  in   1     op_a/op_b/alu_ctrl valid
//  in_ready  out  1     unit can accept; accept = in_valid & in_ready
//  alu_ctrl  in   4     0010 ADD, 0110 SUB, 0000 AND, 0001 OR, 0111 SLT, 0011 SLL, 0100 SRL
//  op_a      in   XLEN  operand A
//  op_b      in   XLEN  operand B
//  out_valid out  1     result/zero/illegal valid
//  out_ready in   1     consumer accepts; transfer = out_valid & out_ready
//  result    out  XLEN  registered result
//  zero      out  1     registered, (result == 0)
//  illegal   out  1     registered; alu_ctrl was not in the table above
// BEHAVIOUR
//  Reset (rst=1 at an edge):
//   - state->IDLE; out_valid, result, zero, illegal, shift count and shift register -> 0.
//   - in_ready is 0 while rst=1.
//   - Reset during SHIFT aborts the op; no result is produced.
//  in_ready (combinational) = !rst & state==IDLE & (!out_valid | out_ready).
//   - This is the only dependency of in_ready on out_ready.
//  FSM states: IDLE, SHIFT.
//  IDLE, accept of a non-shift op, or SLL/SRL with shamt==0:
//   - At the next edge: result = f(op_a,op_b), out_valid = 1, zero/illegal updated, state stays IDLE.
//  IDLE, accept of SLL/SRL with shamt!=0:
//   - Latch op_a into shift register, cnt = shamt, direction; state -> SHIFT; out_valid -> 0 unless re-set.
//  SHIFT:
//   - Each cycle: shift register shifts 1 bit (SLL left, SRL logical right, zero fill); cnt decrements.
//   - The cycle with cnt==1 writes the shifted value into result, sets out_valid=1, and returns to IDLE.
//   - Accept at cycle T gives out_valid at T+1+shamt.
//   - in_ready=0 throughout SHIFT.
//  Arithmetic:
//   - ADD/SUB are modulo 2^XLEN; no carry/overflow outputs.
//   - SLT is a signed compare: result = {XLEN-1 zeros, ($signed(op_a) < $signed(op_b))}.
//   - AND/OR are bitwise.
//   - Only op_b[SHAMT_W-1:0] is used for shifts; the upper bits of op_b are ignored.
//  Illegal code (incl. 1111): result=0, zero=1, illegal=1, out_valid=1 at the next edge.
//   - The pipeline does not stall on an illegal code.
//  Output hold:
//   - While out_valid & !out_ready, result/zero/illegal/out_valid are held stable.
//  Output clear:
//   - On transfer with no new accept in the same cycle, out_valid -> 0.
//   - result/zero/illegal keep their last values.
//  Back-to-back:
//   - A transfer and a new accept in the same cycle leave out_valid=1 with the new result at the next edge.
//   - Sustained throughput is 1 op/cycle for non-shift ops.
//  Inputs when not accepted are ignored.
//  Operands need not stay stable after accept.
// TESTING
//  1. ADD op_a=5, op_b=7, accept at T, out_ready=1 -> at T+1 out_valid=1, result=12, zero=0, illegal=0.
//  2. SUB 9-9 then SLT -1 vs 1, back-to-back, out_ready=1 -> result=0/zero=1, then result=1/zero=0.
//     out_valid stays 1 for 2 consecutive cycles.
//  3. SLL op_a=1, op_b=4 at T -> in_ready=0 on T+1..T+4; out_valid=1 at T+5 with result=0x10.
//     Also SRL 0x80000000 by 31 -> result=1 at T+32.
//  4. ADD 1+1 with out_ready=0 for 3 cycles -> result=2 and out_valid held, in_ready=0.
//     out_ready=1 -> transfer; an op offered in that same cycle is accepted.
//  5. alu_ctrl=1111, op_a=3 -> next cycle out_valid=1, illegal=1, result=0, zero=1.
//  6. rst=1 at cycle 3 of a 10-bit SLL -> out_valid=0 and state IDLE next cycle.
//     No stale result appears afterwards; a following ADD 2+2 returns 4 at accept+1.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes on both sides.
// Single-cycle ops return one cycle after accept; SLL/SRL shift one bit per cycle.
module alu_exec_unit #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SLL = 4'b0011;
    localparam logic [3:0] CTRL_SRL = 4'b0100;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;

    localparam logic [SHAMT_W-1:0] CNT_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [XLEN-1:0]     shreg_q, shreg_d;
    logic [SHAMT_W-1:0]  cnt_q, cnt_d;
    logic                dir_left_q, dir_left_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                zero_q, zero_d;
    logic                illegal_q, illegal_d;
    logic                out_valid_q, out_valid_d;

    logic [XLEN-1:0]     alu_res;
    logic                alu_ill;
    logic                is_shift;
    logic [SHAMT_W-1:0]  shamt;
    logic [XLEN-1:0]     shl_step;
    logic [XLEN-1:0]     shr_step;
    logic [XLEN-1:0]     shift_step;
    logic                accept;
    logic                transfer;

    assign shamt    = op_b[SHAMT_W-1:0];
    assign in_ready = !rst && (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign transfer = out_valid_q && out_ready;

    // One-bit zero-fill shift of the working register in each direction.
    genvar gi;
    generate
        for (gi = 0; gi < XLEN; gi++) begin : g_shift
            if (gi == 0) begin : g_lsb
                assign shl_step[gi] = 1'b0;
            end else begin : g_lmid
                assign shl_step[gi] = shreg_q[gi-1];
            end
            if (gi == XLEN - 1) begin : g_msb
                assign shr_step[gi] = 1'b0;
            end else begin : g_rmid
                assign shr_step[gi] = shreg_q[gi+1];
            end
        end
    endgenerate

    assign shift_step = dir_left_q ? shl_step : shr_step;

    always_comb begin
        alu_res  = '0;
        alu_ill  = 1'b0;
        is_shift = 1'b0;
        case (alu_ctrl)
            CTRL_ADD: alu_res = op_a + op_b;
            CTRL_SUB: alu_res = op_a - op_b;
            CTRL_AND: alu_res = op_a & op_b;
            CTRL_OR:  alu_res = op_a | op_b;
            CTRL_SLT: alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            // A zero-distance shift completes immediately with op_a unchanged.
            CTRL_SLL, CTRL_SRL: begin
                is_shift = 1'b1;
                alu_res  = op_a;
            end
            default:  alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        dir_left_d  = dir_left_q;
        result_d    = result_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_shift && (shamt != '0)) begin
                        state_d     = SHIFT;
                        shreg_d     = op_a;
                        cnt_d       = shamt;
                        dir_left_d  = (alu_ctrl == CTRL_SLL);
                        out_valid_d = 1'b0;
                    end else begin
                        result_d    = alu_res;
                        zero_d      = (alu_res == '0);
                        illegal_d   = alu_ill;
                        out_valid_d = 1'b1;
                    end
                end else if (transfer) begin
                    out_valid_d = 1'b0;
                end
            end
            SHIFT: begin
                shreg_d = shift_step;
                cnt_d   = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    result_d    = shift_step;
                    zero_d      = (shift_step == '0);
                    illegal_d   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            dir_left_q  <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            dir_left_q  <= dir_left_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule
